// File: rtl/load_access_unit_pkg.sv
// Shared definitions for the load access unit: MemCode values, FSM states and size decode.
package load_access_unit_pkg;

    typedef enum logic [3:0] {
        MemLw  = 4'b0000,
        MemLd  = 4'b0001,
        MemLh  = 4'b0010,
        MemLb  = 4'b0011,
        MemLhu = 4'b0100,
        MemLbu = 4'b0101,
        MemLwu = 4'b0110
    } mem_code_e;

    typedef enum logic [2:0] {
        StIdle,
        StReq0,
        StWait0,
        StReq1,
        StWait1,
        StResp
    } lau_state_e;

    // Access size in bytes; 0 for codes outside the MemCode set.
    function automatic logic [3:0] code_size(input logic [3:0] code);
        case (code)
            MemLb, MemLbu:         code_size = 4'd1;
            MemLh, MemLhu:         code_size = 4'd2;
            MemLw, MemLwu:         code_size = 4'd4;
            MemLd:                 code_size = 4'd8;
            default:               code_size = 4'd0;
        endcase
    endfunction

    function automatic logic code_signed(input logic [3:0] code);
        code_signed = (code == MemLb) || (code == MemLh) || (code == MemLw);
    endfunction

    function automatic logic code_legal(input logic [3:0] code, input int unsigned data_w);
        if (code > MemLwu) begin
            code_legal = 1'b0;
        end else if ((code == MemLd || code == MemLwu) && data_w == 32) begin
            code_legal = 1'b0;
        end else begin
            code_legal = 1'b1;
        end
    endfunction

endpackage

// File: rtl/load_access_unit_extract.sv
// Combinational byte/half/word/double extraction from up to two bus beats with sign/zero extension.
module load_access_unit_extract
    import load_access_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned OFF_W = $clog2(DATA_W / 8)
) (
    input  logic [2*DATA_W-1:0] beats,
    input  logic [OFF_W-1:0]    offset,
    input  logic [3:0]          code,
    output logic [DATA_W-1:0]   data
);

    logic [2*DATA_W-1:0] shifted;
    logic [DATA_W-1:0]   low;
    logic [DATA_W-1:0]   hi_mask;
    logic [DATA_W-1:0]   top_mask;
    logic [6:0]          nbits;
    logic                sign;

    always_comb begin
        shifted  = beats >> {offset, 3'b000};
        low      = shifted[DATA_W-1:0];
        nbits    = {code_size(code), 3'b000};
        // Shifting by the full width yields zero, so a full-word load keeps every bit.
        hi_mask  = {DATA_W{1'b1}} << nbits;
        top_mask = ~hi_mask ^ (~hi_mask >> 1);
        sign     = code_signed(code) && (|(low & top_mask));
        data     = (low & ~hi_mask) | (sign ? hi_mask : {DATA_W{1'b0}});
    end

endmodule

// File: rtl/load_access_unit.sv
// Load path from the MEM stage to a word-wide bus: one request, one or two aligned reads,
// extraction, then a held valid/ready response.
module load_access_unit
    import load_access_unit_pkg::*;
#(
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned ADDR_W          = 32,
    parameter bit          ALLOW_UNALIGNED = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_code,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);

    lau_state_e          state;
    logic [OFF_W-1:0]    off_q;
    logic [3:0]          code_q;
    logic [DATA_W-1:0]   beat0;
    logic [2*DATA_W-1:0] ext_beats;
    logic [DATA_W-1:0]   ext_data;
    logic                in_legal;
    logic                in_misaligned;
    logic                q_cross;
    int unsigned         in_off;
    int unsigned         in_size;
    int unsigned         q_end;

    always_comb begin
        in_off        = 32'(req_addr[OFF_W-1:0]);
        in_size       = 32'(code_size(req_code));
        in_legal      = code_legal(req_code, DATA_W);
        in_misaligned = (in_off & (in_size - 1)) != 0;
        q_end         = 32'(off_q) + 32'(code_size(code_q));
        q_cross       = q_end > BYTES;
        // The second beat is only live while it is arriving; one-beat loads see zeros above.
        ext_beats     = (state == StWait1) ? {bus_rdata, beat0} : {{DATA_W{1'b0}}, bus_rdata};
    end

    load_access_unit_extract #(
        .DATA_W(DATA_W)
    ) u_extract (
        .beats (ext_beats),
        .offset(off_q),
        .code  (code_q),
        .data  (ext_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= StIdle;
            off_q     <= '0;
            code_q    <= '0;
            beat0     <= '0;
            req_ready <= 1'b0;
            bus_req   <= 1'b0;
            bus_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        off_q     <= req_addr[OFF_W-1:0];
                        code_q    <= req_code;
                        beat0     <= '0;
                        if (!in_legal || (in_misaligned && !ALLOW_UNALIGNED)) begin
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end else begin
                            state    <= StReq0;
                            bus_req  <= 1'b1;
                            bus_addr <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                StReq0, StReq1: begin
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        state   <= (state == StReq0) ? StWait0 : StWait1;
                    end
                end
                StWait0: begin
                    if (bus_rvalid) begin
                        if (q_cross) begin
                            beat0    <= bus_rdata;
                            state    <= StReq1;
                            bus_req  <= 1'b1;
                            bus_addr <= bus_addr + ADDR_W'(BYTES);
                        end else begin
                            state     <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_data  <= ext_data;
                        end
                    end
                end
                StWait1: begin
                    if (bus_rvalid) begin
                        state     <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_data  <= ext_data;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state     <= StIdle;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_data  <= '0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_load_access_unit.sv
// Directed bench for load_access_unit: 32-bit strict, 32-bit unaligned and 64-bit instances.
module tb_load_access_unit;

    logic        clk;
    logic        reset_n;

    logic        req_valid  [3];
    logic        req_ready  [3];
    logic [31:0] req_addr   [3];
    logic [3:0]  req_code   [3];
    logic        bus_req    [3];
    logic [31:0] bus_addr   [3];
    logic        bus_gnt    [3];
    logic        bus_rvalid [3];
    logic [63:0] bus_rdata  [3];
    logic        rsp_valid  [3];
    logic        rsp_ready  [3];
    logic        rsp_err    [3];
    logic [63:0] rsp_data   [3];
    logic [31:0] rsp_data_0;
    logic [31:0] rsp_data_1;
    logic [63:0] rsp_data_2;

    assign rsp_data[0] = {32'h0, rsp_data_0};
    assign rsp_data[1] = {32'h0, rsp_data_1};
    assign rsp_data[2] = rsp_data_2;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] r_data;
    logic        r_err;
    int          r_nreads;
    logic [31:0] r_addr0;
    logic [31:0] r_addr1;
    int          r_lat;
    logic        r_stable;
    logic        r_ready_ok;
    logic        r_ready_after;

    load_access_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_UNALIGNED(1'b0)) u_dut_strict (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_addr  (req_addr[0]),
        .req_code  (req_code[0]),
        .bus_req   (bus_req[0]),
        .bus_addr  (bus_addr[0]),
        .bus_gnt   (bus_gnt[0]),
        .bus_rvalid(bus_rvalid[0]),
        .bus_rdata (bus_rdata[0][31:0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_ready (rsp_ready[0]),
        .rsp_data  (rsp_data_0),
        .rsp_err   (rsp_err[0])
    );

    load_access_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_UNALIGNED(1'b1)) u_dut_unal (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_addr  (req_addr[1]),
        .req_code  (req_code[1]),
        .bus_req   (bus_req[1]),
        .bus_addr  (bus_addr[1]),
        .bus_gnt   (bus_gnt[1]),
        .bus_rvalid(bus_rvalid[1]),
        .bus_rdata (bus_rdata[1][31:0]),
        .rsp_valid (rsp_valid[1]),
        .rsp_ready (rsp_ready[1]),
        .rsp_data  (rsp_data_1),
        .rsp_err   (rsp_err[1])
    );

    load_access_unit #(.DATA_W(64), .ADDR_W(32), .ALLOW_UNALIGNED(1'b0)) u_dut_wide (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid[2]),
        .req_ready (req_ready[2]),
        .req_addr  (req_addr[2]),
        .req_code  (req_code[2]),
        .bus_req   (bus_req[2]),
        .bus_addr  (bus_addr[2]),
        .bus_gnt   (bus_gnt[2]),
        .bus_rvalid(bus_rvalid[2]),
        .bus_rdata (bus_rdata[2]),
        .rsp_valid (rsp_valid[2]),
        .rsp_ready (rsp_ready[2]),
        .rsp_data  (rsp_data_2),
        .rsp_err   (rsp_err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request and return just after the accepting edge.
    task automatic issue(input int i, input logic [31:0] addr, input logic [3:0] code);
        @(negedge clk);
        req_valid[i] = 1'b1;
        req_addr[i]  = addr;
        req_code[i]  = code;
        for (int k = 0; k < 20 && !req_ready[i]; k++) @(negedge clk);
        if (!req_ready[i]) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout dut=%0d req_ready=%0b want 1", i, req_ready[i]);
        end
        @(posedge clk);
    endtask

    // One full load with a scripted bus and consumer; results land in the r_* variables.
    task automatic run_load(input int i, input logic [31:0] addr, input logic [3:0] code,
                            input logic [63:0] mem0, input logic [63:0] mem1,
                            input int gnt_dly, input int rdy_dly);
        int          gcnt;
        int          rcnt;
        int          beat;
        logic        pend;
        logic        done;
        logic [31:0] cur_addr;
        logic [63:0] held_data;
        gcnt = 0; rcnt = 0; beat = 0; pend = 1'b0; done = 1'b0;
        cur_addr = '0; held_data = '0;
        r_data = '0; r_err = 1'b0; r_nreads = 0; r_addr0 = '0; r_addr1 = '0; r_lat = 0;
        r_stable = 1'b1; r_ready_ok = 1'b1;
        issue(i, addr, code);
        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clk);
            req_valid[i]  = 1'b0;
            bus_gnt[i]    = 1'b0;
            bus_rvalid[i] = 1'b0;
            if (req_ready[i]) r_ready_ok = 1'b0;
            if (pend) begin
                bus_rvalid[i] = 1'b1;
                bus_rdata[i]  = (beat == 0) ? mem0 : mem1;
                beat++;
                pend = 1'b0;
            end else if (bus_req[i]) begin
                if (gcnt == 0) cur_addr = bus_addr[i];
                else if (bus_addr[i] !== cur_addr) r_stable = 1'b0;
                if (gcnt >= gnt_dly) begin
                    bus_gnt[i] = 1'b1;
                    if (r_nreads == 0) r_addr0 = bus_addr[i];
                    else r_addr1 = bus_addr[i];
                    r_nreads++;
                    pend = 1'b1;
                    gcnt = 0;
                end else begin
                    gcnt++;
                end
            end
            if (rsp_valid[i]) begin
                if (r_lat == 0) begin
                    r_lat = k;
                    held_data = rsp_data[i];
                end else if (rsp_data[i] !== held_data) begin
                    r_stable = 1'b0;
                end
                if (rcnt >= rdy_dly) begin
                    rsp_ready[i] = 1'b1;
                    r_data = rsp_data[i];
                    r_err  = rsp_err[i];
                    done   = 1'b1;
                end else begin
                    rcnt++;
                end
            end
        end
        @(negedge clk);
        rsp_ready[i]  = 1'b0;
        bus_rvalid[i] = 1'b0;
        bus_gnt[i]    = 1'b0;
        r_ready_after = req_ready[i];
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL rsp_timeout dut=%0d rsp_valid=%0b want 1", i, rsp_valid[i]);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (req_ready[i] !== 1'b0 || bus_req[i] !== 1'b0 || rsp_valid[i] !== 1'b0 ||
                rsp_err[i] !== 1'b0 || rsp_data[i] !== 64'h0 || bus_addr[i] !== 32'h0) begin
                n_errors++;
                $display("FAIL reset_outputs dut=%0d got rdy=%0b breq=%0b rv=%0b err=%0b data=%h addr=%h want all 0",
                         i, req_ready[i], bus_req[i], rsp_valid[i], rsp_err[i], rsp_data[i],
                         bus_addr[i]);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (req_ready[i] !== 1'b1) begin
                n_errors++;
                $display("FAIL idle_ready dut=%0d got %0b want 1", i, req_ready[i]);
            end
        end
    endtask

    task automatic test_extract32();
        logic [31:0] addrs [5];
        logic [3:0]  codes [5];
        logic [63:0] exps  [5];
        addrs = '{32'h102, 32'h103, 32'h102, 32'h100, 32'h100};
        codes = '{4'b0011, 4'b0101, 4'b0010, 4'b0100, 4'b0000};
        exps  = '{64'hFFFFFF99, 64'h00000088, 64'hFFFF8899, 64'h0000AABB, 64'h8899AABB};
        for (int v = 0; v < 5; v++) begin
            run_load(0, addrs[v], codes[v], 64'h8899AABB, 64'h0, 0, 0);
            n_checks++;
            if (r_data !== exps[v] || r_err !== 1'b0) begin
                n_errors++;
                $display("FAIL extract32 v=%0d got data=%h err=%0b want data=%h err=0",
                         v, r_data, r_err, exps[v]);
            end
        end
        n_checks++;
        if (r_lat !== 3 || r_nreads !== 1 || r_addr0 !== 32'h100) begin
            n_errors++;
            $display("FAIL lw_latency got lat=%0d reads=%0d addr=%h want lat=3 reads=1 addr=00000100",
                     r_lat, r_nreads, r_addr0);
        end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [5];
        logic [3:0]  codes [5];
        addrs = '{32'h1001, 32'h0, 32'h0, 32'h0, 32'h1003};
        codes = '{4'b0000, 4'b0001, 4'b0110, 4'b1000, 4'b0010};
        for (int v = 0; v < 5; v++) begin
            run_load(0, addrs[v], codes[v], 64'h8899AABB, 64'h0, 0, 0);
            n_checks++;
            if (r_err !== 1'b1 || r_data !== 64'h0 || r_nreads !== 0) begin
                n_errors++;
                $display("FAIL error_path v=%0d got err=%0b data=%h reads=%0d want err=1 data=0 reads=0",
                         v, r_err, r_data, r_nreads);
            end
        end
    endtask

    task automatic test_unaligned();
        run_load(1, 32'h1002, 4'b0000, 64'h44332211, 64'h88776655, 0, 0);
        n_checks++;
        if (r_data !== 64'h66554433 || r_err !== 1'b0 || r_nreads !== 2 ||
            r_addr0 !== 32'h1000 || r_addr1 !== 32'h1004 || r_lat !== 5) begin
            n_errors++;
            $display("FAIL split_lw got data=%h err=%0b reads=%0d a0=%h a1=%h lat=%0d want 66554433 0 2 00001000 00001004 5",
                     r_data, r_err, r_nreads, r_addr0, r_addr1, r_lat);
        end
        run_load(1, 32'h1001, 4'b0010, 64'h44332211, 64'h0, 0, 0);
        n_checks++;
        if (r_data !== 64'h00003322 || r_nreads !== 1 || r_lat !== 3) begin
            n_errors++;
            $display("FAIL inword_lh got data=%h reads=%0d lat=%0d want 00003322 1 3",
                     r_data, r_nreads, r_lat);
        end
        run_load(1, 32'h1003, 4'b0100, 64'h44332211, 64'h88776655, 0, 0);
        n_checks++;
        if (r_data !== 64'h00005544 || r_nreads !== 2) begin
            n_errors++;
            $display("FAIL split_lhu got data=%h reads=%0d want 00005544 2", r_data, r_nreads);
        end
        run_load(1, 32'hFFFFFFFE, 4'b0000, 64'hDDCCBBAA, 64'h11223344, 0, 0);
        n_checks++;
        if (r_data !== 64'h3344DDCC || r_addr0 !== 32'hFFFFFFFC || r_addr1 !== 32'h0) begin
            n_errors++;
            $display("FAIL wrap_lw got data=%h a0=%h a1=%h want 3344ddcc fffffffc 00000000",
                     r_data, r_addr0, r_addr1);
        end
    endtask

    task automatic test_wide();
        run_load(2, 32'h8, 4'b0001, 64'h0123456789ABCDEF, 64'h0, 0, 0);
        n_checks++;
        if (r_data !== 64'h0123456789ABCDEF || r_err !== 1'b0 || r_addr0 !== 32'h8) begin
            n_errors++;
            $display("FAIL ld64 got data=%h err=%0b addr=%h want 0123456789abcdef 0 00000008",
                     r_data, r_err, r_addr0);
        end
        run_load(2, 32'h4, 4'b0000, 64'h8000000000000000, 64'h0, 0, 0);
        n_checks++;
        if (r_data !== 64'hFFFFFFFF80000000 || r_addr0 !== 32'h0) begin
            n_errors++;
            $display("FAIL lw64 got data=%h addr=%h want ffffffff80000000 00000000", r_data, r_addr0);
        end
        run_load(2, 32'h4, 4'b0110, 64'h8000000000000000, 64'h0, 0, 0);
        n_checks++;
        if (r_data !== 64'h0000000080000000 || r_err !== 1'b0) begin
            n_errors++;
            $display("FAIL lwu64 got data=%h err=%0b want 0000000080000000 0", r_data, r_err);
        end
        run_load(2, 32'h7, 4'b0011, 64'h8000000000000000, 64'h0, 0, 0);
        n_checks++;
        if (r_data !== 64'hFFFFFFFFFFFFFF80) begin
            n_errors++;
            $display("FAIL lb64 got data=%h want ffffffffffffff80", r_data);
        end
        run_load(2, 32'h4, 4'b0001, 64'h8000000000000000, 64'h0, 0, 0);
        n_checks++;
        if (r_err !== 1'b1 || r_data !== 64'h0 || r_nreads !== 0) begin
            n_errors++;
            $display("FAIL ld64_misaligned got err=%0b data=%h reads=%0d want 1 0 0",
                     r_err, r_data, r_nreads);
        end
    endtask

    task automatic test_backpressure();
        run_load(0, 32'h202, 4'b0010, 64'h8899AABB, 64'h0, 4, 3);
        n_checks++;
        if (r_data !== 64'hFFFF8899 || r_lat !== 7 || r_addr0 !== 32'h200) begin
            n_errors++;
            $display("FAIL bp_result got data=%h lat=%0d addr=%h want ffff8899 7 00000200",
                     r_data, r_lat, r_addr0);
        end
        n_checks++;
        if (r_stable !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_stable got %0b want 1", r_stable);
        end
        n_checks++;
        if (r_ready_ok !== 1'b1 || r_ready_after !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_req_ready got busy_ok=%0b after=%0b want 1 0", r_ready_ok, r_ready_after);
        end
    endtask

    task automatic test_reset_mid();
        issue(0, 32'h21, 4'b0101);
        for (int k = 0; k < 5 && !bus_req[0]; k++) @(negedge clk);
        req_valid[0] = 1'b0;
        n_checks++;
        if (bus_req[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_bus_req got %0b want 1", bus_req[0]);
        end
        bus_gnt[0] = 1'b1;
        @(negedge clk);
        bus_gnt[0] = 1'b0;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus_req[0] !== 1'b0 || rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset got breq=%0b rv=%0b rdy=%0b want 0 0 0",
                     bus_req[0], rsp_valid[0], req_ready[0]);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus_rvalid[0] = 1'b1;
        bus_rdata[0]  = 64'h8899AABB;
        @(negedge clk);
        bus_rvalid[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp_valid[0] !== 1'b0 || bus_req[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL stray_rvalid got rv=%0b breq=%0b want 0 0", rsp_valid[0], bus_req[0]);
        end
        run_load(0, 32'h21, 4'b0101, 64'h8899AABB, 64'h0, 0, 0);
        n_checks++;
        if (r_data !== 64'h000000AA || r_err !== 1'b0 || r_lat !== 3) begin
            n_errors++;
            $display("FAIL post_reset_lbu got data=%h err=%0b lat=%0d want 000000aa 0 3",
                     r_data, r_err, r_lat);
        end
    endtask

    initial begin
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0; req_addr[i] = '0; req_code[i] = '0;
            bus_gnt[i] = 1'b0; bus_rvalid[i] = 1'b0; bus_rdata[i] = '0; rsp_ready[i] = 1'b0;
        end
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_extract32();
        test_errors();
        test_unaligned();
        test_wide();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
